sobel_window_feeder: RTL and testbench
======================================

SOBEL_WINDOW_FEEDER -- requirements
Module: sobel_window_feeder

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 8; pixels per row, legal range 3..1024.
REQ-002 SHALL have parameter IMG_HEIGHT, default 8; rows per frame, legal range 3..1024.
REQ-003 SHALL have one clock and one reset: clock clk, reset rst; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 i_pixel_valid  input  1  upstream pixel present.
REQ-007 i_pixel  input  8  grayscale pixel, raster order (row 0 col 0 first).
REQ-008 o_pixel_ready  output  1  feeder accepts a pixel this cycle.
REQ-009 P0..P8  output  8 each  3x3 window, row-major: P0-P2 oldest row, P3-P5 middle row, P6-P8 newest row; within a row left to right.
REQ-010 o_gradient_start  output  1  one-cycle start pulse to edge_detection.
REQ-011 i_gradient_data_ready  input  1  edge_detection result valid.
REQ-012 i_processed_sum  input  8  edge_detection result.
REQ-013 o_result  output  8  captured processed_sum.
REQ-014 o_result_valid  output  1  one-cycle pulse, o_result updated.
REQ-015 o_frame_done  output  1  one-cycle pulse after last window result of a frame.

Function
REQ-016 Pixel accepted only on a cycle with i_pixel_valid=1 and o_pixel_ready=1.
REQ-017 FSM states: ACCEPT, ISSUE, WAIT; o_pixel_ready=1 only in ACCEPT.
REQ-018 Two line buffers, IMG_WIDTH x 8 each: lb0 = previous row, lb1 = row before that.
REQ-019 On accept at column c: new column = {lb1[c], lb0[c], i_pixel} (top, mid, bottom); lb1[c]<=lb0[c]; lb0[c]<=i_pixel.
REQ-020 On accept, window shifts left: P0<=P1, P1<=P2, P2<=top; P3<=P4, P4<=P5, P5<=mid; P6<=P7, P7<=P8, P8<=bottom.
REQ-021 Column counter wraps IMG_WIDTH-1 -> 0 and increments row; row counter wraps IMG_HEIGHT-1 -> 0.
REQ-022 ACCEPT -> ISSUE on accept at row>=2 and col>=2 (counters before increment); otherwise stay in ACCEPT.
REQ-023 ISSUE lasts exactly one cycle with o_gradient_start=1, then -> WAIT.
REQ-024 i_gradient_data_ready ignored outside WAIT, including during the ISSUE cycle.
REQ-025 In WAIT, on i_gradient_data_ready=1: o_result<=i_processed_sum, o_result_valid pulses the next cycle, state -> ACCEPT.
REQ-026 P0..P8 SHALL hold stable from the ISSUE cycle until the WAIT exit.
REQ-027 Each frame issues exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows; no border padding.
REQ-028 o_frame_done pulses in the same cycle as o_result_valid for the frame's final window.
REQ-029 WAIT has no timeout; the feeder stalls indefinitely, holding o_pixel_ready=0.
REQ-030 i_pixel is not sampled while o_pixel_ready=0; valid pixels offered then are not consumed.

Reset
REQ-031 rst=1 at a rising edge: state=ACCEPT, counters=0, P0..P8=0, o_result=0, all pulses=0; o_pixel_ready=1 the cycle after rst deasserts.
REQ-032 Line buffer contents are not reset; they are never issued before being rewritten in a frame.
REQ-033 rst in ISSUE or WAIT discards the pending window; a later i_gradient_data_ready does not produce o_result_valid.

Verification
REQ-034 IMG_WIDTH=IMG_HEIGHT=3, feed 31,224,224,31,31,224,31,31,224 -> P0..P8 match in order, o_gradient_start one cycle after 9th accept, o_pixel_ready=0 during WAIT.
REQ-035 Same frame, drive i_processed_sum=255 with i_gradient_data_ready=1 five cycles into WAIT -> o_result=255, o_result_valid and o_frame_done pulse together, o_pixel_ready=1 next cycle.
REQ-036 Default 8x8, ramp pixels 0..63, DUT model returns 1 per window -> 36 o_gradient_start pulses; first window P0..P8=0,1,2,8,9,10,16,17,18.
REQ-037 i_pixel_valid held 1 through WAIT -> no pixel consumed until ready returns; counters unchanged.
REQ-038 i_gradient_data_ready=1 during ISSUE only -> no exit from WAIT, no o_result_valid.
REQ-039 rst pulse mid-WAIT, then assert i_gradient_data_ready -> no o_result_valid; next frame restarts at row 0 col 0 with correct windows.

Source files
------------

// File: rtl/sobel_window_feeder.sv
// sobel_window_feeder
// Turns a raster pixel stream into 3x3 windows for an edge_detection unit.
// For each window it sends a start pulse, waits for the result and passes it on.
// Two line buffers hold the previous two rows. A shift window holds the last three columns.
// A window is issued only after at least two full rows and two columns are present,
// so the frame border is never padded.
module sobel_window_feeder #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_pixel_valid,
    input  logic [7:0] i_pixel,
    output logic       o_pixel_ready,
    output logic [7:0] P0,
    output logic [7:0] P1,
    output logic [7:0] P2,
    output logic [7:0] P3,
    output logic [7:0] P4,
    output logic [7:0] P5,
    output logic [7:0] P6,
    output logic [7:0] P7,
    output logic [7:0] P8,
    output logic       o_gradient_start,
    input  logic       i_gradient_data_ready,
    input  logic [7:0] i_processed_sum,
    output logic [7:0] o_result,
    output logic       o_result_valid,
    output logic       o_frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    localparam logic [1:0] ST_ACCEPT = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [7:0]    r_lb0 [IMG_WIDTH];
    logic [7:0]    r_lb1 [IMG_WIDTH];
    logic [7:0]    r_win [9];
    logic          r_last_win;
    logic          r_start;
    logic          r_result_valid;
    logic          r_frame_done;
    logic [7:0]    r_result;

    logic          w_accept;
    logic          w_window;
    logic          w_last;
    logic          w_take;
    logic [7:0]    w_top;
    logic [7:0]    w_mid;

    assign w_accept = i_pixel_valid && (r_state == ST_ACCEPT);
    assign w_window = w_accept && (r_row >= RW'(2)) && (r_col >= CW'(2));
    assign w_last   = (r_row == ROW_LAST) && (r_col == COL_LAST);
    assign w_take   = (r_state == ST_WAIT) && i_gradient_data_ready;
    assign w_top    = r_lb1[r_col];
    assign w_mid    = r_lb0[r_col];

    // Choose the next handshake state. The result input only matters in WAIT.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACCEPT: begin
                if (w_window) begin
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_ACCEPT;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_gradient_data_ready) begin
                    w_state_nxt = ST_ACCEPT;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            default: begin
                w_state_nxt = ST_ACCEPT;
            end
        endcase
    end

    // FSM, raster counters, shift window and result/pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_ACCEPT;
            r_col          <= '0;
            r_row          <= '0;
            r_last_win     <= 1'b0;
            r_start        <= 1'b0;
            r_result_valid <= 1'b0;
            r_frame_done   <= 1'b0;
            r_result       <= 8'd0;
            for (int i = 0; i < 9; i++) begin
                r_win[i] <= 8'd0;
            end
        end else begin
            r_state        <= w_state_nxt;
            r_start        <= w_window;
            r_result_valid <= w_take;
            r_frame_done   <= w_take && r_last_win;
            if (w_take) begin
                r_result <= i_processed_sum;
            end
            if (w_window) begin
                r_last_win <= w_last;
            end
            if (w_accept) begin
                r_win[0] <= r_win[1];
                r_win[1] <= r_win[2];
                r_win[2] <= w_top;
                r_win[3] <= r_win[4];
                r_win[4] <= r_win[5];
                r_win[5] <= w_mid;
                r_win[6] <= r_win[7];
                r_win[7] <= r_win[8];
                r_win[8] <= i_pixel;
                if (r_col == COL_LAST) begin
                    r_col <= '0;
                    if (r_row == ROW_LAST) begin
                        r_row <= '0;
                    end else begin
                        r_row <= r_row + RW'(1);
                    end
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
        end
    end

    // Line buffers are not cleared. Each entry is rewritten before any window uses it.
    always_ff @(posedge clk) begin
        if (w_accept && !rst) begin
            r_lb1[r_col] <= r_lb0[r_col];
            r_lb0[r_col] <= i_pixel;
        end
    end

    assign o_pixel_ready    = (r_state == ST_ACCEPT);
    assign o_gradient_start = r_start;
    assign o_result         = r_result;
    assign o_result_valid   = r_result_valid;
    assign o_frame_done     = r_frame_done;
    assign P0 = r_win[0];
    assign P1 = r_win[1];
    assign P2 = r_win[2];
    assign P3 = r_win[3];
    assign P4 = r_win[4];
    assign P5 = r_win[5];
    assign P6 = r_win[6];
    assign P7 = r_win[7];
    assign P8 = r_win[8];

endmodule

// File: tb/tb_sobel_window_feeder.sv
// Bench for sobel_window_feeder: a directed 3x3 frame plus randomized 8x8 frames.
// The expected values come from a frame-image model in this file.
module tb_sobel_window_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // 8x8 instance (a_*)
    logic       a_rst, a_valid, a_gdr, a_ready, a_start, a_res_v, a_done;
    logic [7:0] a_pix, a_sum, a_res;
    logic [7:0] a_p [9];
    // 3x3 instance (b_*)
    logic       b_rst, b_valid, b_gdr, b_ready, b_start, b_res_v, b_done;
    logic [7:0] b_pix, b_sum, b_res;
    logic [7:0] b_p [9];

    sobel_window_feeder dut_a (
        .clk(clk), .rst(a_rst), .i_pixel_valid(a_valid), .i_pixel(a_pix),
        .o_pixel_ready(a_ready),
        .P0(a_p[0]), .P1(a_p[1]), .P2(a_p[2]), .P3(a_p[3]), .P4(a_p[4]),
        .P5(a_p[5]), .P6(a_p[6]), .P7(a_p[7]), .P8(a_p[8]),
        .o_gradient_start(a_start), .i_gradient_data_ready(a_gdr),
        .i_processed_sum(a_sum), .o_result(a_res), .o_result_valid(a_res_v),
        .o_frame_done(a_done)
    );

    sobel_window_feeder #(.IMG_WIDTH(3), .IMG_HEIGHT(3)) dut_b (
        .clk(clk), .rst(b_rst), .i_pixel_valid(b_valid), .i_pixel(b_pix),
        .o_pixel_ready(b_ready),
        .P0(b_p[0]), .P1(b_p[1]), .P2(b_p[2]), .P3(b_p[3]), .P4(b_p[4]),
        .P5(b_p[5]), .P6(b_p[6]), .P7(b_p[7]), .P8(b_p[8]),
        .o_gradient_start(b_start), .i_gradient_data_ready(b_gdr),
        .i_processed_sum(b_sum), .o_result(b_res), .o_result_valid(b_res_v),
        .o_frame_done(b_done)
    );

    // Counts one comparison and reports it when the values differ.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Counts start pulses on the 8x8 instance.
    int a_start_cnt = 0;
    always @(negedge clk) begin
        if (a_start === 1'b1) a_start_cnt++;
    end

    // Reference model: image of the current frame and the raster position.
    logic [7:0] img [64];
    int m_row = 0;
    int m_col = 0;

    // Sends one pixel into the 8x8 instance. If it completes a window, the task
    // checks the window and serves the result. With rst_in_wait it instead
    // resets the DUT while it waits for the result.
    task automatic feed_a(input logic [7:0] pix, input bit rst_in_wait);
        int guard;
        bit is_win;
        bit is_last;
        logic [7:0] exp_w [9];
        logic [7:0] sum;
        int nwait;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        a_pix = pix;
        a_valid = 1'b1;
        guard = 0;
        while (a_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq("a_ready_at_offer", a_ready, 1);
        img[m_row * 8 + m_col] = pix;
        is_win  = (m_row >= 2) && (m_col >= 2);
        is_last = (m_row == 7) && (m_col == 7);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                exp_w[3 * i + j] = is_win ? img[(m_row - 2 + i) * 8 + (m_col - 2 + j)] : 8'd0;
        if (m_col == 7) begin
            m_col = 0;
            m_row = (m_row == 7) ? 0 : m_row + 1;
        end else begin
            m_col = m_col + 1;
        end
        @(negedge clk);
        if (!is_win) begin
            a_valid = 1'b0;
            check_eq("a_no_start", a_start, 0);
            check_eq("a_ready_after_accept", a_ready, 1);
            return;
        end
        // ISSUE cycle: the window is presented; a result strobe here must be ignored.
        check_eq("a_start", a_start, 1);
        check_eq("a_ready_issue", a_ready, 0);
        for (int i = 0; i < 9; i++) check_eq("a_window", a_p[i], exp_w[i]);
        a_pix = ~pix;
        a_gdr = 1'($urandom_range(0, 1));
        a_sum = 8'($urandom);
        @(negedge clk);
        a_gdr = 1'b0;
        check_eq("a_no_valid_after_issue", a_res_v, 0);
        check_eq("a_start_one_cycle", a_start, 0);
        nwait = $urandom_range(0, 3);
        for (int w = 0; w < nwait; w++) begin
            check_eq("a_ready_wait", a_ready, 0);
            @(negedge clk);
        end
        check_eq("a_window_hold", a_p[4], exp_w[4]);
        if (rst_in_wait) begin
            a_rst = 1'b1;
            a_valid = 1'b0;
            @(negedge clk);
            a_rst = 1'b0;
            m_row = 0;
            m_col = 0;
            check_eq("a_rst_clears_window", a_p[4], 0);
            a_gdr = 1'b1;
            a_sum = 8'hA5;
            for (int w = 0; w < 3; w++) begin
                @(negedge clk);
                check_eq("a_no_valid_after_rst", a_res_v, 0);
            end
            a_gdr = 1'b0;
            check_eq("a_ready_after_rst", a_ready, 1);
            return;
        end
        sum = 8'($urandom);
        a_sum = sum;
        a_gdr = 1'b1;
        @(negedge clk);
        a_gdr = 1'b0;
        a_valid = 1'b0;
        check_eq("a_result_valid", a_res_v, 1);
        check_eq("a_result", a_res, sum);
        check_eq("a_frame_done", a_done, is_last);
        check_eq("a_ready_back", a_ready, 1);
        check_eq("a_window_at_exit", a_p[8], exp_w[8]);
        @(negedge clk);
        check_eq("a_valid_pulse", a_res_v, 0);
        check_eq("a_done_pulse", a_done, 0);
    endtask

    logic [7:0] vec [9];

    initial begin
        vec = '{8'd31, 8'd224, 8'd224, 8'd31, 8'd31, 8'd224, 8'd31, 8'd31, 8'd224};
        a_rst = 1'b1; a_valid = 1'b0; a_gdr = 1'b0; a_pix = 8'd0; a_sum = 8'd0;
        b_rst = 1'b1; b_valid = 1'b0; b_gdr = 1'b0; b_pix = 8'd0; b_sum = 8'd0;
        repeat (3) @(negedge clk);
        a_rst = 1'b0;
        b_rst = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", a_ready, 1);
        check_eq("rst_start", a_start, 0);
        check_eq("rst_result", a_res, 0);
        check_eq("rst_result_valid", a_res_v, 0);
        check_eq("rst_frame_done", a_done, 0);
        for (int i = 0; i < 9; i++) check_eq("rst_window", a_p[i], 0);
        check_eq("rst_b_ready", b_ready, 1);

        // 3x3 directed frame
        b_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            b_pix = vec[k];
            @(negedge clk);
            if (k < 8) check_eq("b_no_start", b_start, 0);
        end
        b_valid = 1'b0;
        check_eq("b_start", b_start, 1);
        for (int i = 0; i < 9; i++) check_eq("b_window", b_p[i], vec[i]);
        for (int w = 0; w < 5; w++) begin
            @(negedge clk);
            check_eq("b_ready_wait", b_ready, 0);
            check_eq("b_no_valid_wait", b_res_v, 0);
        end
        b_sum = 8'd255;
        b_gdr = 1'b1;
        @(negedge clk);
        b_gdr = 1'b0;
        check_eq("b_result", b_res, 255);
        check_eq("b_result_valid", b_res_v, 1);
        check_eq("b_frame_done", b_done, 1);
        check_eq("b_ready_back", b_ready, 1);

        // 8x8 ramp frame
        a_start_cnt = 0;
        for (int k = 0; k < 64; k++) feed_a(8'(k), 1'b0);
        @(negedge clk);
        check_eq("a_ramp_window_count", a_start_cnt, 36);

        // A partial frame reset while waiting on its first window
        for (int k = 0; k < 19; k++) feed_a(8'($urandom), k == 18);

        // A full random frame after the reset must start again at row 0 col 0
        @(negedge clk);
        a_start_cnt = 0;
        for (int k = 0; k < 64; k++) feed_a(8'($urandom), 1'b0);
        @(negedge clk);
        check_eq("a_rand_window_count", a_start_cnt, 36);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
